// File: rtl/symbol_reorder_pkg.sv
// Shared definitions for the symbol reorder buffer: default geometry and
// the per-group emit order.
package symorder_pkg;

  localparam int DEF_SYM_W = 2;
  localparam int DEF_SYMS  = 4;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_REV = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/symbol_reorder_if.sv
// Symbol stream bundle: unthrottled input symbols plus mode, and the
// reordered output stream with group-last and fragment-discard flags.
interface symbol_reorder_if
  import symorder_pkg::*;
#(
  parameter int SYM_W = DEF_SYM_W
);

  logic             axiiv;
  logic [SYM_W-1:0] axiid;
  logic             mode_rev;
  logic             axiov;
  logic [SYM_W-1:0] axiod;
  logic             axiolast;
  logic             frag;

  modport master (
    output axiiv, axiid, mode_rev,
    input  axiov, axiod, axiolast, frag
  );

  modport slave (
    input  axiiv, axiid, mode_rev,
    output axiov, axiod, axiolast, frag
  );

endinterface

// File: rtl/symbol_reorder.sv
// Ping-pong group buffer: collects SYMS symbols, then replays the group in
// arrival or reversed order while the next group fills the other bank.
module symbol_reorder
  import symorder_pkg::*;
#(
  parameter int SYM_W = DEF_SYM_W,
  parameter int SYMS  = DEF_SYMS
) (
  input  logic              clk,
  input  logic              rst_n,
  symbol_reorder_if.slave   bus
);

  if (SYM_W < 1 || SYM_W > 32) begin : g_bad_sym_w
    $error("symbol_reorder: SYM_W must be 1..32");
  end
  if (SYMS < 2 || SYMS > 64 || (SYMS & (SYMS - 1)) != 0) begin : g_bad_syms
    $error("symbol_reorder: SYMS must be a power of two in 2..64");
  end

  localparam int            CW   = $clog2(SYMS);
  localparam logic [CW-1:0] LAST = CW'(SYMS - 1);

  logic [SYM_W-1:0] bank [2][SYMS];
  logic             wr_sel;
  logic [CW-1:0]    rx_cnt;
  logic [CW-1:0]    tx_cnt, tx_cnt_next;
  mode_e            grp_mode;
  mode_e            rd_mode, rd_mode_next;
  rd_state_e        state, state_next;
  logic             frag_q;
  logic             group_done;
  logic [CW-1:0]    rd_idx;
  logic             rd_valid;

  assign group_done = bus.axiiv && (rx_cnt == LAST);

  // Write side: bank fill, group counter, fragment detection and bank swap.
  // NOTE: both banks sit under the async reset so no stale symbols from an
  // abandoned group can ever be replayed; this costs a reset fan-out per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < SYMS; i++)
          bank[b][i] <= '0;
      wr_sel   <= 1'b0;
      rx_cnt   <= '0;
      grp_mode <= MODE_FWD;
      frag_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here let the last symbol land in the
      // old write bank while wr_sel flips on the same edge.
      frag_q <= 1'b0;
      if (bus.axiiv) begin
        bank[wr_sel][rx_cnt] <= bus.axiid;
        rx_cnt               <= rx_cnt + 1'b1;
        if (rx_cnt == '0)
          grp_mode <= mode_e'(bus.mode_rev);
        if (rx_cnt == LAST)
          wr_sel <= ~wr_sel;
      end else if (rx_cnt != '0) begin
        rx_cnt <= '0;
        frag_q <= 1'b1;
      end
    end
  end

  // Readout FSM; a completing group always restarts readout, which keeps
  // axiov gapless when it coincides with the previous group's last symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tx_cnt  <= '0;
      rd_mode <= MODE_FWD;
    end else begin
      state   <= state_next;
      tx_cnt  <= tx_cnt_next;
      rd_mode <= rd_mode_next;
    end
  end

  // NOTE: every signal gets its default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_next   = state;
    tx_cnt_next  = tx_cnt;
    rd_mode_next = rd_mode;
    if (state == ST_READ) begin
      if (tx_cnt == LAST)
        state_next = ST_IDLE;
      else
        tx_cnt_next = tx_cnt + 1'b1;
    end
    if (group_done) begin
      state_next   = ST_READ;
      tx_cnt_next  = '0;
      rd_mode_next = grp_mode;
    end
  end

  assign rd_valid = (state == ST_READ);
  assign rd_idx   = (rd_mode == MODE_REV) ? (LAST - tx_cnt) : tx_cnt;

  assign bus.axiov    = rd_valid;
  assign bus.axiod    = rd_valid ? bank[~wr_sel][rd_idx] : '0;
  assign bus.axiolast = rd_valid && (tx_cnt == LAST);
  assign bus.frag     = frag_q;

endmodule

// File: doc/symbol_reorder.md
SYMBOL_REORDER -- requirements
Module: symbol_reorder

Interface
REQ-001 The module SHALL have parameter SYM_W, default 2, meaning bits per symbol; legal values are 1 to 32.
REQ-002 The module SHALL have parameter SYMS, default 4, meaning symbols per group; legal values are powers of two from 2 to 64.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port axiiv, input, 1 bit: input symbol valid; the input has no backpressure.
REQ-006 The module SHALL have port axiid, input, SYM_W bits: input symbol.
REQ-007 The module SHALL have port mode_rev, input, 1 bit: 1 emits the group in reversed symbol order, 0 emits it in arrival order.
REQ-008 The module SHALL have port axiov, output, 1 bit: output symbol valid.
REQ-009 The module SHALL have port axiod, output, SYM_W bits: output symbol.
REQ-010 The module SHALL have port axiolast, output, 1 bit: high with the final symbol of each emitted group.
REQ-011 The module SHALL have port frag, output, 1 bit: one-cycle pulse when a partial group is discarded.

Function
REQ-012 Storage SHALL be two banks of SYMS x SYM_W, ping-ponged: one write bank and one read bank.
REQ-013 Each cycle with axiiv=1 SHALL write axiid into the write bank at index rx_cnt and increment rx_cnt, which wraps modulo SYMS.
REQ-014 mode_rev SHALL be sampled when rx_cnt=0 and axiiv=1, and held for that group; changes mid-group SHALL have no effect on that group.
REQ-015 Accepting symbol SYMS-1 SHALL swap the banks, latch the group's mode and start readout on the next cycle.
REQ-016 Latency SHALL be: the first output symbol is valid exactly 1 cycle after the group's last input symbol is accepted.
REQ-017 Readout SHALL assert axiov for exactly SYMS consecutive cycles, with tx_cnt running 0..SYMS-1, independent of axiiv.
REQ-018 During readout, axiod SHALL equal read-bank[SYMS-1-tx_cnt] when the latched mode is 1, and read-bank[tx_cnt] when it is 0.
REQ-019 axiolast SHALL be 1 only when axiov=1 and tx_cnt=SYMS-1.
REQ-020 A group completing in the same cycle as the previous readout's last symbol SHALL start readout on the next cycle, giving a gapless axiov; the input rate limit of 1 symbol/cycle guarantees no overrun.
REQ-021 If axiiv=0 while rx_cnt!=0, the module SHALL reset rx_cnt to 0, discard the partial group and pulse frag high for 1 cycle.
REQ-022 axiiv=0 with rx_cnt=0 SHALL cause no action and no frag pulse.
REQ-023 Discarding a partial group SHALL NOT disturb a readout in progress.
REQ-024 When axiov=0, axiod SHALL be 0.
REQ-025 All outputs SHALL be registered or driven from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force axiov=0, axiolast=0, frag=0 and axiod=0.
REQ-027 Asserting rst_n=0 SHALL immediately clear rx_cnt, tx_cnt, the bank select and both banks to 0.
REQ-028 Reset asserted mid-group or mid-readout SHALL abandon all data; no residual output SHALL appear after release.
REQ-029 The first symbol with axiiv=1 after release SHALL be group index 0.

Structure
REQ-030 Shared package symorder_pkg SHALL hold the default SYM_W and SYMS localparams and the mode enum (MODE_FWD=0, MODE_REV=1).
REQ-031 Counter widths SHALL be $clog2(SYMS).
REQ-032 No sub-module is required; banks, counters and control SHALL be inline.
REQ-033 Illegal parameter values SHALL cause an elaboration-time error.

Verification
REQ-034 Defaults, mode_rev=1, input 01,10,11,00 on cycles 0-3 -> axiov cycles 4-7 with axiod 00,11,10,01 and axiolast on cycle 7.
REQ-035 Defaults, mode_rev=0, same input -> axiod 01,10,11,00 on cycles 4-7.
REQ-036 8 back-to-back symbols 00,01,10,11,11,10,01,00 with mode_rev=1 -> axiov high continuously for cycles 4-11: 11,10,01,00,00,01,10,11.
REQ-037 2 symbols, then axiiv=0, then a full group -> 1-cycle frag, no output for the partial group, and the full group is emitted correctly.
REQ-038 rst_n low for 1 cycle during cycle 5 of readout -> axiov=0 at once and stays 0 until a new full group arrives.
REQ-039 SYM_W=8, SYMS=4, mode_rev=1, input 0x11,0x22,0x33,0x44 -> output 0x44,0x33,0x22,0x11.
